// File: rtl/ippcrc_crc32_88b_sch.sv
// Round-robin scheduler sharing one 88-bit CRC-32 core between NCH channels,
// holding a per-channel CRC context so packets may interleave word by word.
// Optional build macro IPPCRC_SCH_CHK_EN adds crc_bad (residue check at EOP).

// Combinational CRC-32 core: 88 data bits folded MSB-first into ci, poly 04C11DB7.
module ippcrc_crc32_88b #(
   parameter logic [31:0] POLY = 32'h04C11DB7
) (
   input  logic [31:0] ci,
   input  logic [87:0] di,
   output logic [31:0] co
);

   logic [31:0] c;
   logic        fb;

   // Serial LFSR unrolled over the whole word.
   always_comb begin
      c  = ci;
      fb = 1'b0;
      for (int i = 87; i >= 0; i--) begin
         fb = c[31] ^ di[i];
         c  = {c[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
      end
      co = c;
   end

endmodule

module ippcrc_crc32_88b_sch #(
   parameter int unsigned NCH     = 4,
   parameter int unsigned CHW     = 2,
   parameter logic [31:0] CINIT   = 32'hFFFFFFFF,
   parameter logic [31:0] FINXOR  = 32'hFFFFFFFF
`ifdef IPPCRC_SCH_CHK_EN
   ,
   parameter logic [31:0] RESIDUE = 32'hC704DD7B
`endif
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cfg_en,
   input  logic [NCH-1:0]      req_vld,
   input  logic [NCH-1:0]      req_sop,
   input  logic [NCH-1:0]      req_eop,
   input  logic [NCH*88-1:0]   req_dat,
   output logic [NCH-1:0]      req_ack,
   output logic                crc_vld,
   output logic [CHW-1:0]      crc_ch,
   output logic [31:0]         crc_val,
`ifdef IPPCRC_SCH_CHK_EN
   output logic                crc_bad,
`endif
   output logic                perr_vld,
   output logic [CHW-1:0]      perr_ch
);

   localparam int unsigned DW = 88;

   logic [31:0]    ctx [NCH];
   logic [NCH-1:0] inpkt;
   logic [CHW-1:0] rr_ptr;

   logic [CHW-1:0] gnt;
   logic [CHW-1:0] idx;
   logic           found;
   logic           gnt_vld;
   int unsigned    sum;

   logic           sel_sop;
   logic           sel_eop;
   logic [DW-1:0]  sel_dat;
   logic [31:0]    core_ci;
   logic [31:0]    core_co;
   logic [CHW-1:0] nxt_rr;

   // Round-robin search starting at rr_ptr; grant is suppressed in reset or when disabled.
   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      sum   = 0;
      for (int unsigned k = 0; k < NCH; k++) begin
         sum = 32'(rr_ptr) + k;
         if (sum >= NCH) sum = sum - NCH;
         idx = CHW'(sum);
         if (!found && req_vld[idx]) begin
            found = 1'b1;
            gnt   = idx;
         end
      end
      gnt_vld = found & cfg_en & ~rst;
      req_ack = '0;
      if (gnt_vld) req_ack[gnt] = 1'b1;
   end

   // Mux the granted channel's word and context into the shared core.
   always_comb begin
      sel_sop = req_sop[gnt];
      sel_eop = req_eop[gnt];
      sel_dat = req_dat[32'(gnt)*DW +: DW];
      core_ci = sel_sop ? CINIT : ctx[gnt];
      nxt_rr  = (32'(gnt) == NCH - 1) ? '0 : gnt + CHW'(1);
   end

   ippcrc_crc32_88b u_core (
      .ci (core_ci),
      .di (sel_dat),
      .co (core_co)
   );

   // Context, packet state, pointer and registered result/error pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NCH; i++) ctx[i] <= CINIT;
         inpkt    <= '0;
         rr_ptr   <= '0;
         crc_vld  <= 1'b0;
         crc_ch   <= '0;
         crc_val  <= '0;
`ifdef IPPCRC_SCH_CHK_EN
         crc_bad  <= 1'b0;
`endif
         perr_vld <= 1'b0;
         perr_ch  <= '0;
      end else begin
         crc_vld  <= 1'b0;
         perr_vld <= 1'b0;
         if (gnt_vld) begin
            rr_ptr <= nxt_rr;
            if (!sel_sop && !inpkt[gnt]) begin
               // Orphan continuation word: consume it, leave the context alone.
               perr_vld <= 1'b1;
               perr_ch  <= gnt;
            end else begin
               ctx[gnt]   <= core_co;
               inpkt[gnt] <= ~sel_eop;
               if (sel_sop && inpkt[gnt]) begin
                  // Restart abandons the open packet.
                  perr_vld <= 1'b1;
                  perr_ch  <= gnt;
               end
               if (sel_eop) begin
                  crc_vld <= 1'b1;
                  crc_ch  <= gnt;
                  crc_val <= core_co ^ FINXOR;
`ifdef IPPCRC_SCH_CHK_EN
                  crc_bad <= (core_co != RESIDUE);
`endif
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_ippcrc_crc32_88b_sch.sv
// Self-checking bench for ippcrc_crc32_88b_sch: per-channel transmit queues,
// a reference arbiter/CRC model and a scoreboard of expected output pulses.
module tb_ippcrc_crc32_88b_sch;

   localparam int NCH = 4;
   localparam int QD  = 32;
   localparam logic [31:0] POLY = 32'h04C11DB7;

   logic              clk = 1'b0;
   logic              rst;
   logic              cfg_en;
   logic [NCH-1:0]    req_vld;
   logic [NCH-1:0]    req_sop;
   logic [NCH-1:0]    req_eop;
   logic [NCH*88-1:0] req_dat;
   logic [NCH-1:0]    req_ack;
   logic              crc_vld;
   logic [1:0]        crc_ch;
   logic [31:0]       crc_val;
   logic              perr_vld;
   logic [1:0]        perr_ch;
`ifdef IPPCRC_SCH_CHK_EN
   logic              crc_bad;
`endif

   ippcrc_crc32_88b_sch dut (
      .clk      (clk),
      .rst      (rst),
      .cfg_en   (cfg_en),
      .req_vld  (req_vld),
      .req_sop  (req_sop),
      .req_eop  (req_eop),
      .req_dat  (req_dat),
      .req_ack  (req_ack),
      .crc_vld  (crc_vld),
      .crc_ch   (crc_ch),
      .crc_val  (crc_val),
`ifdef IPPCRC_SCH_CHK_EN
      .crc_bad  (crc_bad),
`endif
      .perr_vld (perr_vld),
      .perr_ch  (perr_ch)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        sop;
      logic        eop;
      logic [87:0] dat;
   } word_t;

   typedef struct {
      int          cyc;
      logic        crc;
      logic [1:0]  ch;
      logic [31:0] val;
      logic        bad;
      logic        perr;
      logic [1:0]  pch;
   } exp_t;

   typedef struct {
      int          ch;
      logic        sop;
      logic        eop;
      logic [87:0] dat;
      int          exp_crc;
      int          exp_perr;
   } vec_t;

   word_t       tx_mem [NCH][QD];
   int          tx_wr [NCH];
   int          tx_rd [NCH];
   logic [31:0] m_ctx [NCH];
   logic        m_inpkt [NCH];
   int          m_rr;
   exp_t        sbq [$];
   int          cyc;
   int          n_vec;
   int          n_err;
   int          seen_crc;
   int          seen_perr;
   int          acks_seen;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // Byte-at-a-time reference CRC, first byte taken from the top of the word.
   function automatic logic [31:0] m_byte(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c ^ {b, 24'h0};
      for (int j = 0; j < 8; j++) r = r[31] ? ((r << 1) ^ POLY) : (r << 1);
      return r;
   endfunction

   function automatic logic [31:0] m_word(input logic [31:0] c, input logic [87:0] d);
      logic [31:0] r;
      r = c;
      for (int k = 10; k >= 0; k--) r = m_byte(r, d[8*k +: 8]);
      return r;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NCH; i++) begin
         m_ctx[i]   = 32'hFFFFFFFF;
         m_inpkt[i] = 1'b0;
      end
      m_rr = 0;
   endtask

   task automatic enq(input int ch, input logic sop, input logic eop, input logic [87:0] dat);
      if (tx_rd[ch] == tx_wr[ch]) begin
         tx_rd[ch] = 0;
         tx_wr[ch] = 0;
      end
      tx_mem[ch][tx_wr[ch]] = '{sop: sop, eop: eop, dat: dat};
      tx_wr[ch]++;
   endtask

   function automatic int pending();
      int n;
      n = sbq.size();
      for (int i = 0; i < NCH; i++) n += tx_wr[i] - tx_rd[i];
      return n;
   endfunction

   task automatic drive();
      for (int ch = 0; ch < NCH; ch++) begin
         if (tx_rd[ch] < tx_wr[ch]) begin
            req_vld[ch]          = 1'b1;
            req_sop[ch]          = tx_mem[ch][tx_rd[ch]].sop;
            req_eop[ch]          = tx_mem[ch][tx_rd[ch]].eop;
            req_dat[ch*88 +: 88] = tx_mem[ch][tx_rd[ch]].dat;
         end else begin
            req_vld[ch]          = 1'b0;
            req_sop[ch]          = 1'b0;
            req_eop[ch]          = 1'b0;
            req_dat[ch*88 +: 88] = '0;
         end
      end
   endtask

   // One clock: drive, check at the falling edge, advance the model, step past the rising edge.
   task automatic cycle_step();
      logic [NCH-1:0] exp_ack;
      int             g;
      int             id;
      exp_t           e;
      word_t          w;
      logic [31:0]    c;
      drive();
      @(negedge clk);
      exp_ack = '0;
      g       = -1;
      if (cfg_en && !rst) begin
         for (int k = 0; k < NCH; k++) begin
            id = (m_rr + k) % NCH;
            if (g < 0 && req_vld[id]) g = id;
         end
      end
      if (g >= 0) exp_ack[g] = 1'b1;
      chk("ack", 64'(req_ack), 64'(exp_ack));

      if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
         e = sbq.pop_front();
         chk("crc_vld", 64'(crc_vld), 64'(e.crc));
         if (e.crc) begin
            chk("crc_ch", 64'(crc_ch), 64'(e.ch));
            chk("crc_val", 64'(crc_val), 64'(e.val));
`ifdef IPPCRC_SCH_CHK_EN
            chk("crc_bad", 64'(crc_bad), 64'(e.bad));
`endif
         end
         chk("perr_vld", 64'(perr_vld), 64'(e.perr));
         if (e.perr) chk("perr_ch", 64'(perr_ch), 64'(e.pch));
      end else begin
         chk("idle_pulses", 64'({crc_vld, perr_vld}), 64'(0));
      end
      if (crc_vld === 1'b1) seen_crc++;
      if (perr_vld === 1'b1) seen_perr++;

      if (rst) begin
         model_reset();
      end else if (g >= 0) begin
         w = tx_mem[g][tx_rd[g]];
         tx_rd[g]++;
         acks_seen++;
         m_rr = (g + 1) % NCH;
         e = '{cyc: cyc + 1, crc: 1'b0, ch: 2'(g), val: '0, bad: 1'b0, perr: 1'b0, pch: 2'(g)};
         if (!w.sop && !m_inpkt[g]) begin
            e.perr = 1'b1;
         end else begin
            c = m_word(w.sop ? 32'hFFFFFFFF : m_ctx[g], w.dat);
            m_ctx[g] = c;
            e.perr = w.sop && m_inpkt[g];
            m_inpkt[g] = !w.eop;
            if (w.eop) begin
               e.crc = 1'b1;
               e.val = c ^ 32'hFFFFFFFF;
               e.bad = (c != 32'hC704DD7B);
            end
         end
         if (e.crc || e.perr) sbq.push_back(e);
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic drain(input int max, output int n);
      n = 0;
      while (pending() > 0 && n < max) begin
         cycle_step();
         n++;
      end
      chk("drain_left", 64'(pending()), 64'(0));
   endtask

   vec_t        vt [10];
   int          n;
   int          a0;
   logic [95:0] r96;
   logic [87:0] d;
   logic [31:0] c7;

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish, cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0] = '{ch: 0, sop: 1'b1, eop: 1'b1, dat: 88'h0,                       exp_crc: 1, exp_perr: 0};
      vt[1] = '{ch: 2, sop: 1'b0, eop: 1'b0, dat: 88'h1234,                    exp_crc: 0, exp_perr: 1};
      vt[2] = '{ch: 2, sop: 1'b1, eop: 1'b1, dat: 88'hA5A5_5A5A_0F0F_F0F0_1234_56, exp_crc: 1, exp_perr: 0};
      vt[3] = '{ch: 1, sop: 1'b1, eop: 1'b0, dat: 88'hFFFF_FFFF_FFFF_FFFF_FFFF_FF, exp_crc: 0, exp_perr: 0};
      vt[4] = '{ch: 1, sop: 1'b1, eop: 1'b1, dat: 88'h1,                       exp_crc: 1, exp_perr: 1};
      vt[5] = '{ch: 3, sop: 1'b1, eop: 1'b0, dat: 88'h0102_0304_0506_0708_090A_0B, exp_crc: 0, exp_perr: 0};
      vt[6] = '{ch: 3, sop: 1'b0, eop: 1'b0, dat: 88'h8000_0000_0000_0000_0000_00, exp_crc: 0, exp_perr: 0};
      vt[7] = '{ch: 3, sop: 1'b0, eop: 1'b1, dat: 88'hDEAD_BEEF_CAFE_F00D_0000_01, exp_crc: 1, exp_perr: 0};
      vt[8] = '{ch: 0, sop: 1'b0, eop: 1'b1, dat: 88'h55,                      exp_crc: 0, exp_perr: 1};
      vt[9] = '{ch: 0, sop: 1'b1, eop: 1'b1, dat: 88'h55,                      exp_crc: 1, exp_perr: 0};

      n_vec = 0; n_err = 0; cyc = 0; seen_crc = 0; seen_perr = 0; acks_seen = 0;
      for (int i = 0; i < NCH; i++) begin
         tx_wr[i] = 0;
         tx_rd[i] = 0;
      end
      model_reset();
      rst = 1'b1; cfg_en = 1'b1;
      req_vld = '0; req_sop = '0; req_eop = '0; req_dat = '0;
      repeat (2) @(posedge clk);
      #1;

      // Reset values visible after the reset edges.
      chk("rst_outputs", {crc_vld, perr_vld, crc_ch, perr_ch, crc_val}, 64'(0));
      cycle_step();
      rst = 1'b0;

      // Directed single-word vectors, one at a time.
      for (int v = 0; v < 10; v++) begin
         seen_crc = 0; seen_perr = 0;
         enq(vt[v].ch, vt[v].sop, vt[v].eop, vt[v].dat);
         drain(10, n);
         cycle_step();
         chk("tbl_crc_cnt", 64'(seen_crc), 64'(vt[v].exp_crc));
         chk("tbl_perr_cnt", 64'(seen_perr), 64'(vt[v].exp_perr));
      end

      // All four channels streaming 3-word packets back to back.
      seen_crc = 0; a0 = acks_seen;
      for (int p = 0; p < 2; p++) begin
         for (int ch = 0; ch < NCH; ch++) begin
            for (int w = 0; w < 3; w++) begin
               r96 = {$urandom(), $urandom(), $urandom()};
               enq(ch, w == 0, w == 2, r96[87:0]);
            end
         end
      end
      drain(60, n);
      chk("rr_cycles", 64'(n), 64'(25));
      chk("rr_acks", 64'(acks_seen - a0), 64'(24));
      chk("rr_crcs", 64'(seen_crc), 64'(8));

      // Reset in the middle of a ch3 packet.
      enq(3, 1'b1, 1'b0, 88'h3333);
      enq(3, 1'b0, 1'b0, 88'h4444);
      enq(3, 1'b0, 1'b1, 88'h5555);
      cycle_step();
      rst = 1'b1;
      cycle_step();
      rst = 1'b0;
      tx_rd[3] = tx_wr[3];
      chk("midrst_outputs", {crc_vld, perr_vld, crc_ch, perr_ch, crc_val}, 64'(0));
      seen_crc = 0;
      enq(3, 1'b1, 1'b0, 88'h0BAD_F00D);
      enq(3, 1'b0, 1'b1, 88'h1357_9BDF);
      drain(10, n);
      cycle_step();
      chk("midrst_crc_cnt", 64'(seen_crc), 64'(1));

      // Arbitration disabled for five cycles, then resumes from the held pointer.
      enq(2, 1'b1, 1'b1, 88'h22);
      drain(10, n);
      cfg_en = 1'b0;
      a0 = acks_seen;
      for (int ch = 0; ch < NCH; ch++) enq(ch, 1'b1, 1'b1, 88'(ch + 16));
      repeat (5) cycle_step();
      chk("cfg_off_acks", 64'(acks_seen - a0), 64'(0));
      cfg_en = 1'b1;
      drain(20, n);
      chk("cfg_on_acks", 64'(acks_seen - a0), 64'(4));

`ifdef IPPCRC_SCH_CHK_EN
      // Seven data bytes plus their FCS form one word; the residue must match.
      d  = 88'h6162_6364_6566_6700_0000_00;
      c7 = 32'hFFFFFFFF;
      for (int k = 10; k >= 4; k--) c7 = m_byte(c7, d[8*k +: 8]);
      d[31:0] = c7 ^ 32'hFFFFFFFF;
      enq(1, 1'b1, 1'b1, d);
      drain(10, n);
      d[50] = ~d[50];
      enq(1, 1'b1, 1'b1, d);
      drain(10, n);
      chk("fcs_bad_flag", 64'(crc_bad), 64'(1));
`endif

      cycle_step();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
